// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the five-stage RISC-V core with load-use hazard
// detection, bubble insertion, flush/hold handling and a saturating bubble counter.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        hold,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [2:0]  id_funct3,
  input  logic [6:0]  id_funct7,
  input  logic [1:0]  id_aluop,
  input  logic        id_alusrc,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_regwrite,
  input  logic        id_memtoreg,
  input  logic        id_branch,
  input  logic        id_jump,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic [6:0]  ex_funct7,
  output logic [1:0]  ex_aluop,
  output logic        ex_alusrc,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_regwrite,
  output logic        ex_memtoreg,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        stall,
  output logic [15:0] bubble_count
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        memtoreg;
    logic        branch;
    logic        jump;
  } ex_bundle_t;

  ex_bundle_t  id_bundle;
  ex_bundle_t  ex_d, ex_q;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;
  logic        load_use;

  assign id_bundle = '{
    valid:    id_valid,
    pc:       id_pc,
    rd1:      id_rd1,
    rd2:      id_rd2,
    imm:      id_imm,
    rs1:      id_rs1,
    rs2:      id_rs2,
    rd:       id_rd,
    funct3:   id_funct3,
    funct7:   id_funct7,
    aluop:    id_aluop,
    alusrc:   id_alusrc,
    memread:  id_memread,
    memwrite: id_memwrite,
    regwrite: id_regwrite,
    memtoreg: id_memtoreg,
    branch:   id_branch,
    jump:     id_jump
  };

  // Both source indices are compared whatever the format; I-type false stalls are accepted.
  always_comb begin
    load_use = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) && id_valid &&
               ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
  end

  assign stall = load_use & ~flush;

  // A bubble is the all-zero bundle, so EX sees a harmless invalid ADD 0+0.
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (!hold) begin
      if (load_use) begin
        ex_d = '0;
        if (bubble_cnt_q != '1) begin
          bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
      end else begin
        ex_d = id_bundle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rd1       = ex_q.rd1;
  assign ex_rd2       = ex_q.rd2;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7    = ex_q.funct7;
  assign ex_aluop     = ex_q.aluop;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_memread   = ex_q.memread;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a cycle-level
// reference model of the pipeline register and hazard rules.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        memtoreg;
    logic        branch;
    logic        jump;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        hold;
  instr_t      idv;
  instr_t      obs;
  logic        stall;
  logic [15:0] bubble_count;

  instr_t      exp_q;
  logic [15:0] exp_cnt;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .hold        (hold),
    .id_valid    (idv.valid),
    .id_pc       (idv.pc),
    .id_rd1      (idv.rd1),
    .id_rd2      (idv.rd2),
    .id_imm      (idv.imm),
    .id_rs1      (idv.rs1),
    .id_rs2      (idv.rs2),
    .id_rd       (idv.rd),
    .id_funct3   (idv.funct3),
    .id_funct7   (idv.funct7),
    .id_aluop    (idv.aluop),
    .id_alusrc   (idv.alusrc),
    .id_memread  (idv.memread),
    .id_memwrite (idv.memwrite),
    .id_regwrite (idv.regwrite),
    .id_memtoreg (idv.memtoreg),
    .id_branch   (idv.branch),
    .id_jump     (idv.jump),
    .ex_valid    (obs.valid),
    .ex_pc       (obs.pc),
    .ex_rd1      (obs.rd1),
    .ex_rd2      (obs.rd2),
    .ex_imm      (obs.imm),
    .ex_rs1      (obs.rs1),
    .ex_rs2      (obs.rs2),
    .ex_rd       (obs.rd),
    .ex_funct3   (obs.funct3),
    .ex_funct7   (obs.funct7),
    .ex_aluop    (obs.aluop),
    .ex_alusrc   (obs.alusrc),
    .ex_memread  (obs.memread),
    .ex_memwrite (obs.memwrite),
    .ex_regwrite (obs.regwrite),
    .ex_memtoreg (obs.memtoreg),
    .ex_branch   (obs.branch),
    .ex_jump     (obs.jump),
    .stall       (stall),
    .bubble_count(bubble_count)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Hazard as the model sees it: a valid load in EX whose nonzero rd feeds ID.
  function automatic logic model_hazard();
    if (!reset || !exp_q.valid || !exp_q.memread || exp_q.rd == 5'd0 || !idv.valid) return 1'b0;
    return (exp_q.rd == idv.rs1) || (exp_q.rd == idv.rs2);
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.valid    = ($urandom_range(0, 3) != 0);
    t.pc       = $urandom;
    t.rd1      = $urandom;
    t.rd2      = $urandom;
    t.imm      = $urandom;
    t.rs1      = 5'($urandom_range(0, 7));
    t.rs2      = 5'($urandom_range(0, 7));
    t.rd       = 5'($urandom_range(0, 7));
    t.funct3   = 3'($urandom);
    t.funct7   = 7'($urandom);
    t.aluop    = 2'($urandom);
    t.alusrc   = 1'($urandom);
    t.memread  = 1'($urandom);
    t.memwrite = 1'($urandom);
    t.regwrite = 1'($urandom);
    t.memtoreg = 1'($urandom);
    t.branch   = 1'($urandom);
    t.jump     = 1'($urandom);
    return t;
  endfunction

  function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic memread);
    instr_t t;
    t         = rand_instr();
    t.valid   = 1'b1;
    t.rd      = rd;
    t.rs1     = rs1;
    t.rs2     = rs2;
    t.memread = memread;
    return t;
  endfunction

  // Inputs are already applied; check stall mid-cycle, clock, then check EX state.
  task automatic cycle(input string tag);
    logic haz;
    #2;
    haz = model_hazard();
    check({tag, ".stall"}, 256'(stall), 256'(haz & ~flush));
    @(posedge clk);
    if (flush) begin
      exp_q = '0;
    end else if (!hold) begin
      if (haz) begin
        exp_q = '0;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end else begin
        exp_q = idv;
      end
    end
    #1;
    check({tag, ".ex"}, 256'(obs), 256'(exp_q));
    check({tag, ".bubbles"}, 256'(bubble_count), 256'(exp_cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ex"}, 256'(obs), 256'(0));
    check({tag, ".bubbles"}, 256'(bubble_count), 256'(0));
    check({tag, ".stall"}, 256'(stall), 256'(0));
  endtask

  initial begin
    reset   = 1'b0;
    flush   = 1'b0;
    hold    = 1'b0;
    idv     = '0;
    exp_q   = '0;
    exp_cnt = '0;
    #3;
    check_all_zero("por");
    #9 reset = 1'b1;
    cycle("first");

    // Build up three bubbles, then load an instruction with rd=5, regwrite=1.
    for (int i = 0; i < 3; i++) begin
      idv = mk(5'd5, 5'd1, 5'd2, 1'b1);
      cycle("pre_lw");
      idv = mk(5'd9, 5'd5, 5'd3, 1'b0);
      cycle("pre_use");
      cycle("pre_cap");
    end
    idv = mk(5'd5, 5'd1, 5'd2, 1'b0);
    idv.regwrite = 1'b1;
    cycle("pre_rd5");
    check("pre.cnt3", 256'(bubble_count), 256'(16'd3));
    check("pre.rd5", 256'({obs.rd, obs.regwrite}), 256'({5'd5, 1'b1}));

    // Asynchronous reset between edges, with a dependent instruction in ID.
    idv = mk(5'd6, 5'd5, 5'd5, 1'b0);
    #3 reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_q   = '0;
    exp_cnt = '0;
    #1 reset = 1'b1;
    idv = '0;
    cycle("post_rst");

    // Load-use: LW x5 then ADD rs1=5 -> one bubble, then ADD enters EX.
    idv = mk(5'd5, 5'd1, 5'd2, 1'b1);
    cycle("lu_lw");
    idv = mk(5'd10, 5'd5, 5'd11, 1'b0);
    cycle("lu_use");
    check("lu.bubble", 256'({obs.valid, obs.aluop, bubble_count}), 256'({1'b0, 2'b00, 16'd1}));
    cycle("lu_cap");
    check("lu.captured", 256'({obs.valid, obs.rd}), 256'({1'b1, 5'd10}));

    // x0 destination never stalls; non-matching indices capture normally.
    idv = mk(5'd0, 5'd1, 5'd2, 1'b1);
    cycle("x0_lw");
    idv = mk(5'd12, 5'd0, 5'd0, 1'b0);
    cycle("x0_use");
    idv = mk(5'd5, 5'd1, 5'd2, 1'b1);
    cycle("nd_lw");
    idv = mk(5'd13, 5'd6, 5'd7, 1'b0);
    cycle("nd_use");

    // Flush beats hold and load-use; no stall, bubble, count unchanged.
    idv = mk(5'd5, 5'd1, 5'd2, 1'b1);
    cycle("fl_lw");
    idv   = mk(5'd14, 5'd5, 5'd5, 1'b0);
    flush = 1'b1;
    hold  = 1'b1;
    cycle("fl_all");
    flush = 1'b0;
    hold  = 1'b0;

    // Hold for three cycles with changing ID inputs, then capture on release.
    idv = mk(5'd15, 5'd1, 5'd2, 1'b0);
    cycle("hd_load");
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idv = mk(5'd16, 5'd3, 5'd4, 1'b0);
      cycle("hd_freeze");
    end
    hold = 1'b0;
    idv = mk(5'd17, 5'd3, 5'd4, 1'b0);
    cycle("hd_release");

    // Randomized mix of flush, hold and frequent hazards.
    for (int i = 0; i < 400; i++) begin
      idv   = rand_instr();
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      cycle("rand");
    end
    flush = 1'b0;
    hold  = 1'b0;

    // Saturation: preset the counter just below the ceiling, then two more bubbles.
    @(negedge clk);
    force dut.bubble_cnt_q = 16'hFFFE;
    #1 release dut.bubble_cnt_q;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      idv = mk(5'd5, 5'd1, 5'd2, 1'b1);
      cycle("sat_lw");
      idv = mk(5'd18, 5'd2, 5'd5, 1'b0);
      cycle("sat_use");
      check("sat.cnt", 256'(bubble_count), 256'(16'hFFFF));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
